// File: rtl/hazard_pkg.sv
// hazard_pkg: stage indices, default parameters and select-width helper for the hazard unit
package hazard_pkg;
    localparam int EX = 1;
    localparam int MA = 2;
    localparam int RW = 3;
    localparam int D_XLEN     = 32;
    localparam int D_NREG     = 16;
    localparam int D_NSTAGE   = RW;
    localparam int D_LD_STAGE = MA;
    localparam int D_MC_LAT   = 4;
    function automatic int sw_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction
endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: OF-stage instruction info, operand buses and hazard controls
interface pipeline_hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int XLEN   = D_XLEN,
    parameter int NREG   = D_NREG,
    parameter int NSTAGE = D_NSTAGE
);
    localparam int RW_W = $clog2(NREG);
    localparam int SW   = sw_width(NSTAGE);
    logic                   of_valid;
    logic [RW_W-1:0]        of_rs1, of_rs2;
    logic                   of_use1, of_use2;
    logic                   of_wr, of_ld, of_mc;
    logic [RW_W-1:0]        of_rd;
    logic [XLEN-1:0]        rf_a, rf_b;
    logic [NSTAGE*XLEN-1:0] stage_res;
    logic                   branch_taken;
    logic                   stall_front, bubble_ex, flush_of, ex_hold;
    logic [SW-1:0]          fwd_a, fwd_b;
    logic [XLEN-1:0]        op_a, op_b;
    modport master (
        output of_valid, of_rs1, of_rs2, of_use1, of_use2, of_wr, of_rd, of_ld, of_mc,
        output rf_a, rf_b, stage_res, branch_taken,
        input  stall_front, bubble_ex, flush_of, ex_hold, fwd_a, fwd_b, op_a, op_b
    );
    modport slave (
        input  of_valid, of_rs1, of_rs2, of_use1, of_use2, of_wr, of_rd, of_ld, of_mc,
        input  rf_a, rf_b, stage_res, branch_taken,
        output stall_front, bubble_ex, flush_of, ex_hold, fwd_a, fwd_b, op_a, op_b
    );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: youngest-stage match for one source operand, operand mux and load-use detect
module fwd_select
    import hazard_pkg::*;
#(
    parameter int XLEN     = D_XLEN,
    parameter int NREG     = D_NREG,
    parameter int NSTAGE   = D_NSTAGE,
    parameter int LD_STAGE = D_LD_STAGE
) (
    input  logic                        of_valid,
    input  logic                        use_src,
    input  logic [$clog2(NREG)-1:0]     src,
    input  logic [NSTAGE:1]             valid,
    input  logic [NSTAGE:1]             wr,
    input  logic [NSTAGE:1]             ld,
    input  logic [NSTAGE:1][$clog2(NREG)-1:0] rd,
    input  logic [XLEN-1:0]             rf,
    input  logic [NSTAGE*XLEN-1:0]      stage_res,
    output logic [sw_width(NSTAGE)-1:0] sel,
    output logic [XLEN-1:0]             op,
    output logic                        ld_hit
);
    localparam int SW = sw_width(NSTAGE);
    logic [NSTAGE:1] hit;
    // scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        sel    = '0;
        op     = rf;
        ld_hit = 1'b0;
        for (int k = NSTAGE; k >= EX; k--) begin
            hit[k] = of_valid & use_src & valid[k] & wr[k] & (rd[k] == src);
            if (hit[k]) begin
                sel = SW'(k);
                op  = stage_res[(k-1)*XLEN +: XLEN];
            end
            ld_hit = ld_hit | (hit[k] & ld[k] & (k < LD_STAGE));
        end
    end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: forwarding, load-use stall, multi-cycle hold and branch flush control
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int XLEN     = D_XLEN,
    parameter int NREG     = D_NREG,
    parameter int NSTAGE   = D_NSTAGE,
    parameter int LD_STAGE = D_LD_STAGE,
    parameter int MC_LAT   = D_MC_LAT
) (
    input logic                    clk,
    input logic                    reset,
    pipeline_hazard_unit_if.slave  bus
);
    localparam int RW_W = $clog2(NREG);
    localparam int CW   = $clog2(MC_LAT + 1);
    logic [NSTAGE:1]           sh_valid, sh_wr, sh_ld;
    logic [NSTAGE:1][RW_W-1:0] sh_rd;
    logic [CW-1:0]             cnt;
    logic                      ld_a, ld_b, flush;

    fwd_select #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .LD_STAGE(LD_STAGE)) u_fwd_a (
        .of_valid(bus.of_valid), .use_src(bus.of_use1), .src(bus.of_rs1),
        .valid(sh_valid), .wr(sh_wr), .ld(sh_ld), .rd(sh_rd),
        .rf(bus.rf_a), .stage_res(bus.stage_res),
        .sel(bus.fwd_a), .op(bus.op_a), .ld_hit(ld_a)
    );
    fwd_select #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .LD_STAGE(LD_STAGE)) u_fwd_b (
        .of_valid(bus.of_valid), .use_src(bus.of_use2), .src(bus.of_rs2),
        .valid(sh_valid), .wr(sh_wr), .ld(sh_ld), .rd(sh_rd),
        .rf(bus.rf_b), .stage_res(bus.stage_res),
        .sel(bus.fwd_b), .op(bus.op_b), .ld_hit(ld_b)
    );

    // hold beats everything; a taken branch squashes OF so its load-use stall is dropped
    always_comb begin
        bus.ex_hold     = cnt != '0;
        flush           = bus.branch_taken & ~bus.ex_hold;
        bus.flush_of    = flush;
        bus.stall_front = bus.ex_hold | ((ld_a | ld_b) & ~flush);
        bus.bubble_ex   = ~bus.ex_hold & (flush | ld_a | ld_b);
    end

    // shadow pipeline advance; during a hold EX keeps its entry and MA takes a bubble
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_valid <= '0;
            sh_wr    <= '0;
            sh_ld    <= '0;
            sh_rd    <= '0;
            cnt      <= '0;
        end else begin
            for (int k = NSTAGE; k > EX; k--) begin
                sh_valid[k] <= (k == MA && bus.ex_hold) ? 1'b0 : sh_valid[k-1];
                sh_wr[k]    <= sh_wr[k-1];
                sh_ld[k]    <= sh_ld[k-1];
                sh_rd[k]    <= sh_rd[k-1];
            end
            if (!bus.ex_hold) begin
                sh_valid[EX] <= bus.of_valid & ~bus.bubble_ex;
                sh_wr[EX]    <= bus.of_wr;
                sh_ld[EX]    <= bus.of_ld;
                sh_rd[EX]    <= bus.of_rd;
            end
            cnt <= bus.ex_hold ? cnt - 1'b1 :
                   (bus.of_valid & ~bus.bubble_ex & bus.of_mc) ? CW'(MC_LAT - 1) : '0;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed scenarios plus random traffic against an in-flight instruction model
module tb_pipeline_hazard_unit;
    import hazard_pkg::*;
    localparam int XLEN = 32, NREG = 16, NSTAGE = 3, LD_STAGE = 2, MC_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // in-flight instructions by stage: 1=EX, 2=MA, 3=RW
    logic m_v[1:3], m_wr[1:3], m_ld[1:3];
    int   m_rd[1:3];
    int   m_busy;
    logic e_hold, e_bubble;

    pipeline_hazard_unit_if #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE)) bus ();
    pipeline_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .NSTAGE(NSTAGE), .LD_STAGE(LD_STAGE), .MC_LAT(MC_LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int v, input int rs1, input int rs2, input int u1, input int u2,
                       input int wr, input int rd, input int ld, input int mc, input int bt);
        bus.of_valid = 1'(v);   bus.of_rs1 = 4'(rs1); bus.of_rs2 = 4'(rs2);
        bus.of_use1 = 1'(u1);   bus.of_use2 = 1'(u2);
        bus.of_wr = 1'(wr);     bus.of_rd = 4'(rd);   bus.of_ld = 1'(ld); bus.of_mc = 1'(mc);
        bus.branch_taken = 1'(bt);
        bus.rf_a = $urandom;    bus.rf_b = $urandom;
        bus.stage_res = {$urandom, $urandom, $urandom};
    endtask

    function automatic bit reads(input int k, input logic use_src, input int src);
        return bus.of_valid && use_src && m_v[k] && m_wr[k] && m_rd[k] == src;
    endfunction

    // compare every output against what the in-flight model says for the current inputs
    task automatic look(input string tag);
        int sa, sb;
        bit lu, fl;
        logic [31:0] ea, eb;
        #1;
        sa = 0; sb = 0; lu = 0;
        for (int k = 1; k <= 3; k++) begin
            if (sa == 0 && reads(k, bus.of_use1, int'(bus.of_rs1))) sa = k;
            if (sb == 0 && reads(k, bus.of_use2, int'(bus.of_rs2))) sb = k;
            if (k < LD_STAGE && m_ld[k] &&
                (reads(k, bus.of_use1, int'(bus.of_rs1)) || reads(k, bus.of_use2, int'(bus.of_rs2)))) lu = 1;
        end
        e_hold   = m_busy > 0;
        fl       = bus.branch_taken && !e_hold;
        e_bubble = !e_hold && (fl || lu);
        ea = sa == 0 ? bus.rf_a : bus.stage_res[(sa-1)*32 +: 32];
        eb = sb == 0 ? bus.rf_b : bus.stage_res[(sb-1)*32 +: 32];
        chk({tag, ".ex_hold"}, 32'(bus.ex_hold), 32'(e_hold));
        chk({tag, ".flush_of"}, 32'(bus.flush_of), 32'(fl));
        chk({tag, ".stall_front"}, 32'(bus.stall_front), 32'(e_hold || (lu && !fl)));
        chk({tag, ".bubble_ex"}, 32'(bus.bubble_ex), 32'(e_bubble));
        chk({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(sa));
        chk({tag, ".fwd_b"}, 32'(bus.fwd_b), 32'(sb));
        chk({tag, ".op_a"}, bus.op_a, ea);
        chk({tag, ".op_b"}, bus.op_b, eb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int k = 1; k <= 3; k++) m_v[k] = 0;
            m_busy = 0;
        end else if (e_hold) begin
            m_v[3] = m_v[2]; m_wr[3] = m_wr[2]; m_ld[3] = m_ld[2]; m_rd[3] = m_rd[2];
            m_v[2] = 0;
            m_busy--;
        end else begin
            for (int k = 3; k > 1; k--) begin
                m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_v[1]  = bus.of_valid && !e_bubble;
            m_wr[1] = bus.of_wr; m_ld[1] = bus.of_ld; m_rd[1] = int'(bus.of_rd);
            m_busy  = (bus.of_valid && !e_bubble && bus.of_mc) ? MC_LAT - 1 : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 1; k <= 3; k++) begin m_v[k] = 0; m_wr[k] = 0; m_ld[k] = 0; m_rd[k] = 0; end
        m_busy = 0;
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        drv(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        look("reset");
        chk("reset.fwd_a0", 32'(bus.fwd_a), 0);
        chk("reset.op_a_rf", bus.op_a, bus.rf_a);
        chk("reset.stall0", 32'(bus.stall_front), 0);
        tick();
        reset = 1'b1;

        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); look("add_r1"); tick();
        drv(1, 1, 7, 1, 1, 1, 8, 0, 0, 0); look("use_r1");
        chk("use_r1.fwd_a", 32'(bus.fwd_a), 1);
        chk("use_r1.op_a", bus.op_a, bus.stage_res[31:0]);
        chk("use_r1.nostall", 32'(bus.stall_front), 0);
        tick();

        drv(1, 0, 0, 0, 0, 1, 2, 1, 0, 0); look("ld_r2"); tick();
        drv(1, 9, 2, 1, 1, 1, 9, 0, 0, 0); look("lu_stall");
        chk("lu.stall", 32'(bus.stall_front), 1);
        chk("lu.bubble", 32'(bus.bubble_ex), 1);
        tick();
        drv(1, 9, 2, 1, 1, 1, 9, 0, 0, 0); look("lu_release");
        chk("lu2.stall", 32'(bus.stall_front), 0);
        chk("lu2.fwd_b", 32'(bus.fwd_b), 2);
        chk("lu2.op_b", bus.op_b, bus.stage_res[63:32]);
        tick();

        drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); look("w3a"); tick();
        drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); look("w4");  tick();
        drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); look("w3b"); tick();
        drv(1, 3, 3, 1, 1, 0, 0, 0, 0, 0); look("young");
        chk("young.fwd_a", 32'(bus.fwd_a), 1);
        chk("young.fwd_b", 32'(bus.fwd_b), 1);
        tick();

        drv(1, 0, 0, 0, 0, 1, 5, 0, 1, 0); look("div"); tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 5, 0, 1, 0, 1, 6, 0, 0, 0); look("div_hold");
            chk("div.hold", 32'(bus.ex_hold), 1);
            chk("div.stall", 32'(bus.stall_front), 1);
            tick();
        end
        drv(1, 5, 0, 1, 0, 1, 6, 0, 0, 0); look("div_rel");
        chk("div.release", 32'(bus.ex_hold), 0);
        tick();

        drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0); look("ld_r6"); tick();
        drv(1, 6, 0, 1, 0, 1, 7, 0, 0, 1); look("br_lu");
        chk("br.flush", 32'(bus.flush_of), 1);
        chk("br.bubble", 32'(bus.bubble_ex), 1);
        chk("br.stall", 32'(bus.stall_front), 0);
        tick();

        drv(1, 0, 0, 0, 0, 1, 5, 0, 1, 0); look("div2"); tick();
        drv(1, 5, 5, 1, 1, 0, 0, 0, 0, 0); look("div2_hold"); tick();
        reset = 1'b0;
        drv(1, 5, 5, 1, 1, 0, 0, 0, 0, 0); look("rst_mid"); tick();
        reset = 1'b1;
        drv(1, 5, 5, 1, 1, 0, 0, 0, 0, 0); look("post_rst");
        chk("post.hold", 32'(bus.ex_hold), 0);
        chk("post.fwd_a", 32'(bus.fwd_a), 0);
        chk("post.op_b", bus.op_b, bus.rf_b);
        tick();

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drv(int'($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 9) < 7),
                $urandom_range(0, 3), int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 9) == 0));
            look("rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameters: XLEN=32 (operand width); NREG=16 (architectural registers); NSTAGE=3 (tracked stages after OF, index 1=EX, 2=MA, 3=RW); LD_STAGE=2 (first stage whose result input carries load data); MC_LAT=4 (EX occupancy cycles of DIV/MOD).
REQ-002 Derived: RW=$clog2(NREG); SW=$clog2(NSTAGE+1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 of_valid  in  1  OF holds a real instruction.
REQ-006 of_rs1, of_rs2  in  RW each  OF source registers.
REQ-007 of_use1, of_use2  in  1 each  source actually read.
REQ-008 of_wr, of_rd, of_ld, of_mc  in  1/RW/1/1  OF writes reg, dest reg, is load, is multi-cycle (DIV/MOD).
REQ-009 rf_a, rf_b  in  XLEN each  register-file read data for rs1/rs2.
REQ-010 stage_res  in  NSTAGE*XLEN  result of stage k in slice k-1.
REQ-011 branch_taken  in  1  EX resolved taken branch (predict not-taken).
REQ-012 stall_front  out  1  hold PC and IF/OF latch.
REQ-013 bubble_ex  out  1  load NOP into OF/EX latch.
REQ-014 flush_of  out  1  replace IF/OF contents with NOP.
REQ-015 ex_hold  out  1  EX and OF/EX latch hold (multi-cycle op in EX).
REQ-016 fwd_a, fwd_b  out  SW each  source select: 0=register file, k=stage k.
REQ-017 op_a, op_b  out  XLEN each  forwarded operands.

Function
REQ-018 Shadow pipeline SHALL hold per stage {valid, wr, rd, ld}; advances one stage per cycle unless ex_hold=1.
REQ-019 When ex_hold=1, EX entry SHALL stay and stage 2 SHALL receive a bubble; stages 2..NSTAGE still advance.
REQ-020 Entry into EX SHALL be the OF instruction, or a bubble when bubble_ex=1 or of_valid=0.
REQ-021 Match on stage k: entry valid, wr=1, rd equals source, source used, of_valid=1.
REQ-022 fwd SHALL select the lowest-index (youngest) matching stage; none -> 0; op = rf or stage_res slice accordingly.
REQ-023 Load-use: a match on stage k<LD_STAGE whose entry has ld=1 SHALL assert stall_front=1 and bubble_ex=1 for one cycle.
REQ-024 Multi-cycle: when an of_mc instruction enters EX, counter SHALL load MC_LAT-1; ex_hold=1 while counter nonzero, decrementing each cycle; MC_LAT=1 gives no hold.
REQ-025 While ex_hold=1, stall_front=1 and bubble_ex=0; no OF instruction advances.
REQ-026 branch_taken=1 (sampled only when ex_hold=0) SHALL assert flush_of=1 and bubble_ex=1 that cycle and override stall_front to 0.
REQ-027 Simultaneous load-use and branch_taken: flush wins; the squashed OF instruction SHALL NOT cause a stall.
REQ-028 Flush/bubble entries SHALL be valid=0 and never match.
REQ-029 All select/stall/flush outputs combinational from shadow state and OF inputs; zero-cycle latency.

Reset
REQ-030 reset=0 at clock edge SHALL clear all shadow valid bits and the counter; consequently stall_front, bubble_ex, flush_of, ex_hold=0, fwd_a=fwd_b=0, op_a=rf_a, op_b=rf_b.
REQ-031 Reset mid-hold SHALL abort the multi-cycle count; first post-reset cycle has ex_hold=0.

Structure
REQ-032 Shared package hazard_pkg SHALL hold stage index constants (EX=1, MA=2, RW=3), default parameter values and SW derivation.
REQ-033 One sub-module fwd_select (one per operand): priority match over NSTAGE entries -> select and operand mux.

Verification
REQ-034 ADD r1 in EX, OF ADD reads r1 -> fwd_a=1, op_a=stage_res[EX], no stall.
REQ-035 LD r2 in EX, OF SUB reads r2 -> stall_front=1, bubble_ex=1 one cycle; next cycle fwd=2, op=stage_res[MA].
REQ-036 r3 written in EX and RW simultaneously, OF reads r3 -> fwd=1 (youngest wins).
REQ-037 DIV enters EX, MC_LAT=4 -> ex_hold=1 and stall_front=1 for exactly 3 cycles, then release.
REQ-038 branch_taken=1 with load-use pending in OF -> flush_of=1, bubble_ex=1, stall_front=0.
REQ-039 reset=0 during DIV hold -> next cycle all outputs at reset values, shadow empty.
